tpu_cfg_bridge: RTL

//  Parametrised successor bridge between the UART controller and mlp_top. Passes weight-FIFO and activation

---
 rtl/tpu_bridge_pkg.sv | 55 +++++
 rtl/tpu_cfg_regfile.sv | 35 +++
 rtl/tpu_cfg_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tpu_bridge_pkg.sv
// Shared types and constants for the UART-to-MLP configuration bridge.
package tpu_bridge_pkg;

    typedef enum logic [1:0] {
        B_IDLE   = 2'd0,
        B_COMMIT = 2'd1,
        B_LAUNCH = 2'd2,
        B_RUN    = 2'd3
    } bridge_state_e;

    localparam logic [2:0] CFG_ADDR_GAIN      = 3'd0;
    localparam logic [2:0] CFG_ADDR_BIAS      = 3'd1;
    localparam logic [2:0] CFG_ADDR_SHIFT     = 3'd2;
    localparam logic [2:0] CFG_ADDR_INV_SCALE = 3'd3;
    localparam logic [2:0] CFG_ADDR_ZP        = 3'd4;

    localparam logic signed [15:0] GAIN_1Q8      = 16'sd256;
    localparam logic signed [31:0] BIAS_ZERO     = 32'sd0;
    localparam logic        [4:0]  SHIFT_Q8      = 5'd8;
    localparam logic signed [15:0] INV_SCALE_1Q8 = 16'sd256;
    localparam logic signed [7:0]  ZP_ZERO       = 8'sd0;

    typedef struct packed {
        logic signed [15:0] gain;
        logic signed [31:0] bias;
        logic        [4:0]  shift;
        logic signed [15:0] inv_scale;
        logic signed [7:0]  zero_point;
    } norm_cfg_t;

    localparam norm_cfg_t CFG_RESET = '{
        gain:       GAIN_1Q8,
        bias:       BIAS_ZERO,
        shift:      SHIFT_Q8,
        inv_scale:  INV_SCALE_1Q8,
        zero_point: ZP_ZERO
    };

    // Addresses 5-7 leave the register set untouched; fields keep only their low bits.
    function automatic norm_cfg_t cfg_write(input norm_cfg_t cur, input logic [2:0] addr,
                                            input logic [31:0] data);
        norm_cfg_t nxt;
        nxt = cur;
        case (addr)
            CFG_ADDR_GAIN:      nxt.gain       = data[15:0];
            CFG_ADDR_BIAS:      nxt.bias       = data;
            CFG_ADDR_SHIFT:     nxt.shift      = data[4:0];
            CFG_ADDR_INV_SCALE: nxt.inv_scale  = data[15:0];
            CFG_ADDR_ZP:        nxt.zero_point = data[7:0];
            default:            nxt            = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tpu_cfg_regfile.sv
// Shadow/active normalisation config: writes land in shadow, commit copies shadow to active.
module tpu_cfg_regfile
    import tpu_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    output norm_cfg_t   active_cfg
);

    norm_cfg_t shadow_q, shadow_d;
    norm_cfg_t active_q, active_d;

    always_comb begin
        shadow_d = wr_en ? cfg_write(shadow_q, wr_addr, wr_data) : shadow_q;
        active_d = commit ? shadow_q : active_q;
    end

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= CFG_RESET;
            active_q <= CFG_RESET;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_cfg = active_q;

endmodule

// File: rtl/tpu_cfg_bridge.sv
// Bridge between UART controller and mlp_top: traffic pass-through, config commit,
// start sequencing, run watch, acc0 capture and sticky protocol errors.
module tpu_cfg_bridge
    import tpu_bridge_pkg::*;
#(
    parameter int NUM_COLS   = 2,
    parameter int WF_W       = 8,
    parameter int ACT_W      = 16,
    parameter int ACC_W      = 32,
    parameter int STATE_W    = 4,
    parameter int CNT_W      = 5,
    parameter int IDLE_STATE = 0,
    parameter int LAUNCH_TO  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] ctrl_wf_push,
    input  logic [WF_W-1:0]     ctrl_wf_data_in,
    input  logic                ctrl_wf_reset,
    input  logic                ctrl_init_act_valid,
    input  logic [ACT_W-1:0]    ctrl_init_act_data,
    input  logic                ctrl_start_mlp,
    input  logic                ctrl_weights_ready,
    input  logic                cfg_wr_en,
    input  logic [2:0]          cfg_addr,
    input  logic [31:0]         cfg_wr_data,
    input  logic                cfg_commit,
    input  logic                err_clr,
    output logic [NUM_COLS-1:0] mlp_wf_push,
    output logic [WF_W-1:0]     mlp_wf_data_in,
    output logic                mlp_wf_reset,
    output logic                mlp_init_act_valid,
    output logic [ACT_W-1:0]    mlp_init_act_data,
    output logic                mlp_start_mlp,
    output logic                mlp_weights_ready,
    output logic signed [15:0]  mlp_norm_gain,
    output logic signed [31:0]  mlp_norm_bias,
    output logic        [4:0]   mlp_norm_shift,
    output logic signed [15:0]  mlp_q_inv_scale,
    output logic signed [7:0]   mlp_q_zero_point,
    input  logic [STATE_W-1:0]  mlp_state_in,
    input  logic [CNT_W-1:0]    mlp_cycle_cnt_in,
    input  logic [ACC_W-1:0]    mlp_acc0_in,
    output logic [STATE_W-1:0]  mlp_state,
    output logic [CNT_W-1:0]    mlp_cycle_cnt,
    output logic [ACC_W-1:0]    mlp_acc0,
    output logic                run_done,
    output logic                busy,
    output logic                commit_pend,
    output logic                err_wf,
    output logic                err_drop,
    output logic                err_timeout
);

    localparam int                 TMR_W    = $clog2(LAUNCH_TO + 1);
    localparam logic [STATE_W-1:0] IDLE_ENC = STATE_W'(IDLE_STATE);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(LAUNCH_TO - 1);

    bridge_state_e    state_q, state_d;
    logic             start_pend_q, start_pend_d;
    logic             commit_pend_q, commit_pend_d;
    logic             seen_busy_q, seen_busy_d;
    logic             launch_q, launch_d;
    logic             run_done_q, run_done_d;
    logic             err_wf_q, err_wf_d;
    logic             err_drop_q, err_drop_d;
    logic             err_timeout_q, err_timeout_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ACC_W-1:0] acc0_q, acc0_d;

    logic      mlp_idle, push_mask, start_eff, commit_eff;
    norm_cfg_t active_cfg;

    assign mlp_idle   = (mlp_state_in == IDLE_ENC);
    assign push_mask  = (state_q == B_LAUNCH) || (state_q == B_RUN);
    assign start_eff  = start_pend_q | ctrl_start_mlp;
    assign commit_eff = commit_pend_q | cfg_commit;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        start_pend_d  = start_eff;
        commit_pend_d = commit_eff;
        seen_busy_d   = seen_busy_q;
        launch_d      = 1'b0;
        run_done_d    = 1'b0;
        timer_d       = timer_q;
        acc0_d        = acc0_q;
        err_wf_d      = (err_wf_q & ~err_clr) | (push_mask & (|ctrl_wf_push));
        err_drop_d    = (err_drop_q & ~err_clr)
                      | (ctrl_start_mlp & start_pend_q & (state_q != B_LAUNCH));
        err_timeout_d = err_timeout_q & ~err_clr;

        case (state_q)
            B_IDLE: begin
                if (mlp_idle && (commit_eff || start_eff)) begin
                    if (commit_eff) begin
                        state_d = B_COMMIT;
                    end else begin
                        state_d  = B_LAUNCH;
                        launch_d = 1'b1;
                    end
                end
            end
            B_COMMIT: begin
                commit_pend_d = cfg_commit;
                if (start_eff) begin
                    state_d  = B_LAUNCH;
                    launch_d = 1'b1;
                end else begin
                    state_d = B_IDLE;
                end
            end
            B_LAUNCH: begin
                // A start arriving alongside the launch is a fresh request, not a drop.
                start_pend_d = ctrl_start_mlp;
                timer_d      = '0;
                seen_busy_d  = 1'b0;
                state_d      = B_RUN;
            end
            B_RUN: begin
                seen_busy_d = seen_busy_q | ~mlp_idle;
                if (seen_busy_q && mlp_idle) begin
                    acc0_d     = mlp_acc0_in;
                    run_done_d = 1'b1;
                    state_d    = B_IDLE;
                end else if (!seen_busy_q && mlp_idle && (timer_q == TMR_LAST)) begin
                    err_timeout_d = 1'b1;
                    state_d       = B_IDLE;
                end else if (!seen_busy_q) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= B_IDLE;
            start_pend_q  <= 1'b0;
            commit_pend_q <= 1'b0;
            seen_busy_q   <= 1'b0;
            launch_q      <= 1'b0;
            run_done_q    <= 1'b0;
            timer_q       <= '0;
            acc0_q        <= '0;
            err_wf_q      <= 1'b0;
            err_drop_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_pend_q  <= start_pend_d;
            commit_pend_q <= commit_pend_d;
            seen_busy_q   <= seen_busy_d;
            launch_q      <= launch_d;
            run_done_q    <= run_done_d;
            timer_q       <= timer_d;
            acc0_q        <= acc0_d;
            err_wf_q      <= err_wf_d;
            err_drop_q    <= err_drop_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    tpu_cfg_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cfg_wr_en),
        .wr_addr    (cfg_addr),
        .wr_data    (cfg_wr_data),
        .commit     (state_q == B_COMMIT),
        .active_cfg (active_cfg)
    );

    assign mlp_wf_push        = push_mask ? '0 : ctrl_wf_push;
    assign mlp_wf_data_in     = ctrl_wf_data_in;
    assign mlp_wf_reset       = ctrl_wf_reset;
    assign mlp_init_act_valid = ctrl_init_act_valid;
    assign mlp_init_act_data  = ctrl_init_act_data;
    assign mlp_weights_ready  = ctrl_weights_ready;
    assign mlp_start_mlp      = launch_q;

    assign mlp_norm_gain    = active_cfg.gain;
    assign mlp_norm_bias    = active_cfg.bias;
    assign mlp_norm_shift   = active_cfg.shift;
    assign mlp_q_inv_scale  = active_cfg.inv_scale;
    assign mlp_q_zero_point = active_cfg.zero_point;

    assign mlp_state     = mlp_state_in;
    assign mlp_cycle_cnt = mlp_cycle_cnt_in;
    assign mlp_acc0      = acc0_q;
    assign run_done      = run_done_q;
    assign busy          = (state_q != B_IDLE);
    assign commit_pend   = commit_pend_q;
    assign err_wf        = err_wf_q;
    assign err_drop      = err_drop_q;
    assign err_timeout   = err_timeout_q;

endmodule
